// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the decode stage.
// Issues in-order word requests to instruction memory, tags each request with
// its address/mode/PID/TID, buffers returned instructions in a small FIFO and
// presents them to decode with a monotonically increasing major ID.
// Redirects flush the buffer and discard responses that are still in flight.
// Optional feature macro: FETCH_PERF_CTR_EN adds stallCycles_o and flushDrops_o.

// Flags a response that would be written into an already full buffer.
module fetch_unit_checker (
    input logic clock,
    input logic reset,
    input logic respWrite,
    input logic fifoFull
);
    noOverflow: assert property (@(posedge clock) disable iff (reset) !(respWrite && fifoFull));
endmodule

module fetch_unit #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int fifoDepth               = 4
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               start_i,
    input  logic [addressWidth-1:0]            startAddress_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 pid_i,
    input  logic [TidSize-1:0]                 tid_i,
    input  logic                               redirect_i,
    input  logic [addressWidth-1:0]            redirectAddress_i,
    output logic                               memReq_o,
    output logic [addressWidth-1:0]            memAddr_o,
    input  logic                               memReqReady_i,
    input  logic                               memRespValid_i,
    input  logic [instructionWidth-1:0]        memRespData_i,
    input  logic                               stall_i,
    output logic                               enable_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 instructionPid_o,
    output logic [TidSize-1:0]                 instructionTid_o,
`ifdef FETCH_PERF_CTR_EN
    output logic [31:0]                        stallCycles_o,
    output logic [31:0]                        flushDrops_o,
`endif
    output logic [instructionCounterWidth-1:0] instructionMajId_o
);

    localparam int PTR_W = $clog2(fifoDepth);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = addressWidth + 1 + PidSize + TidSize;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [CNT_W-1:0]        CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]        CNT_ONE    = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]        CNT_DEPTH  = CNT_W'(fifoDepth);
    localparam logic [CNT_W:0]          SLOT_LIMIT = (CNT_W + 1)'(fifoDepth);
    localparam logic [PTR_W-1:0]        PTR_ONE    = {{(PTR_W - 1){1'b0}}, 1'b1};
    localparam logic [addressWidth-1:0] ALIGN_MASK = {{(addressWidth - 2){1'b1}}, 2'b00};
    localparam logic [addressWidth-1:0] PC32_MASK  = {{(addressWidth - 32){1'b0}}, {32{1'b1}}};
    localparam logic [addressWidth-1:0] PC_STEP    = {{(addressWidth - 3){1'b0}}, 3'b100};
    localparam logic [instructionCounterWidth-1:0] MAJ_ONE =
        {{(instructionCounterWidth - 1){1'b0}}, 1'b1};

    logic [1:0]              state_r;
    logic [addressWidth-1:0] pc_r;
    logic [CNT_W-1:0]        outstanding_r;
    logic [CNT_W-1:0]        dropCount_r;
    logic [CNT_W-1:0]        fifoWrPtr_r;
    logic [CNT_W-1:0]        fifoRdPtr_r;
    logic [PTR_W-1:0]        tagWrPtr_r;
    logic [PTR_W-1:0]        tagRdPtr_r;
    logic [instructionCounterWidth-1:0] majId_r;

    logic [TAG_W-1:0]            tagQueue_r [fifoDepth];
    logic [TAG_W-1:0]            fifoTag_r  [fifoDepth];
    logic [instructionWidth-1:0] fifoData_r [fifoDepth];

    logic [CNT_W-1:0]        occupancy_s;
    logic [CNT_W:0]          usedSlots_s;
    logic                    fifoEmpty_s;
    logic                    fifoFull_s;
    logic                    reqAccept_s;
    logic                    redirectTake_s;
    logic                    respWrite_s;
    logic                    respCounted_s;
    logic                    pop_s;
    logic [CNT_W-1:0]        outstandingNext_s;
    logic [addressWidth-1:0] pcInc_s;
    logic [addressWidth-1:0] pcNext_s;
    logic [TAG_W-1:0]        headTag_s;

    // Buffer bookkeeping, credit check and per-cycle handshake decisions.
    always_comb begin
        occupancy_s    = fifoWrPtr_r - fifoRdPtr_r;
        usedSlots_s    = {1'b0, occupancy_s} + {1'b0, outstanding_r};
        fifoEmpty_s    = (occupancy_s == CNT_ZERO);
        fifoFull_s     = (occupancy_s == CNT_DEPTH);
        memReq_o       = (state_r == RUN) && (usedSlots_s < SLOT_LIMIT);
        memAddr_o      = pc_r;
        reqAccept_s    = memReq_o && memReqReady_i;
        redirectTake_s = redirect_i && (state_r != IDLE);
        respWrite_s    = memRespValid_i && (state_r == RUN) && !redirectTake_s;
        respCounted_s  = memRespValid_i && (outstanding_r != CNT_ZERO);
        pop_s          = !stall_i && !fifoEmpty_s && !redirectTake_s;
        outstandingNext_s = outstanding_r + (reqAccept_s ? CNT_ONE : CNT_ZERO)
                                          - (respCounted_s ? CNT_ONE : CNT_ZERO);
        pcInc_s        = pc_r + PC_STEP;
        // 32-bit mode wraps the PC at 2^32 by clearing the upper bits.
        pcNext_s       = is64Bit_i ? pcInc_s : (pcInc_s & PC32_MASK);
        headTag_s      = fifoTag_r[fifoRdPtr_r[PTR_W-1:0]];
    end

    // Fetch control FSM: PC, in-flight request count and redirect drop count.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_r       <= IDLE;
            pc_r          <= {addressWidth{1'b0}};
            outstanding_r <= CNT_ZERO;
            dropCount_r   <= CNT_ZERO;
        end else if (redirectTake_s) begin
            // Every request still in flight (including one accepted right now)
            // is stale; a response landing this cycle is already discarded.
            pc_r          <= redirectAddress_i & ALIGN_MASK;
            outstanding_r <= outstandingNext_s;
            dropCount_r   <= outstandingNext_s;
            state_r       <= (outstandingNext_s != CNT_ZERO) ? FLUSH : RUN;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        pc_r    <= startAddress_i & ALIGN_MASK;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    outstanding_r <= outstandingNext_s;
                    if (reqAccept_s) begin
                        pc_r <= pcNext_s;
                    end
                end
                FLUSH: begin
                    outstanding_r <= outstandingNext_s;
                    if (dropCount_r == CNT_ZERO) begin
                        state_r <= RUN;
                    end else if (memRespValid_i) begin
                        dropCount_r <= dropCount_r - CNT_ONE;
                        if (dropCount_r == CNT_ONE) begin
                            state_r <= RUN;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Side-queue and buffer pointers; a redirect empties both.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            tagWrPtr_r  <= {PTR_W{1'b0}};
            tagRdPtr_r  <= {PTR_W{1'b0}};
            fifoWrPtr_r <= CNT_ZERO;
            fifoRdPtr_r <= CNT_ZERO;
        end else if (redirectTake_s) begin
            tagWrPtr_r  <= {PTR_W{1'b0}};
            tagRdPtr_r  <= {PTR_W{1'b0}};
            fifoWrPtr_r <= CNT_ZERO;
            fifoRdPtr_r <= CNT_ZERO;
        end else begin
            tagWrPtr_r  <= tagWrPtr_r + (reqAccept_s ? PTR_ONE : {PTR_W{1'b0}});
            tagRdPtr_r  <= tagRdPtr_r + (respWrite_s ? PTR_ONE : {PTR_W{1'b0}});
            fifoWrPtr_r <= fifoWrPtr_r + (respWrite_s ? CNT_ONE : CNT_ZERO);
            fifoRdPtr_r <= fifoRdPtr_r + (pop_s ? CNT_ONE : CNT_ZERO);
        end
    end

    // Storage: request tags captured at acceptance, responses joined with their tag.
    always_ff @(posedge clock_i) begin
        if (reqAccept_s && !redirectTake_s) begin
            tagQueue_r[tagWrPtr_r] <= {pc_r, is64Bit_i, pid_i, tid_i};
        end
        if (respWrite_s) begin
            fifoData_r[fifoWrPtr_r[PTR_W-1:0]] <= memRespData_i;
            fifoTag_r[fifoWrPtr_r[PTR_W-1:0]]  <= tagQueue_r[tagRdPtr_r];
        end
    end

    // Decode-facing output register: pop when not stalled, hold under stall.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            enable_o             <= 1'b0;
            instruction_o        <= {instructionWidth{1'b0}};
            instructionAddress_o <= {addressWidth{1'b0}};
            is64Bit_o            <= 1'b0;
            instructionPid_o     <= {PidSize{1'b0}};
            instructionTid_o     <= {TidSize{1'b0}};
            instructionMajId_o   <= {instructionCounterWidth{1'b0}};
            majId_r              <= {instructionCounterWidth{1'b0}};
        end else if (redirectTake_s) begin
            enable_o <= 1'b0;
        end else if (!stall_i) begin
            if (pop_s) begin
                enable_o             <= 1'b1;
                instruction_o        <= fifoData_r[fifoRdPtr_r[PTR_W-1:0]];
                {instructionAddress_o, is64Bit_o, instructionPid_o, instructionTid_o} <= headTag_s;
                instructionMajId_o   <= majId_r;
                majId_r              <= majId_r + MAJ_ONE;
            end else begin
                enable_o <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CTR_EN
    logic respDrop_s;

    // A response is discarded while flushing or when it coincides with a redirect.
    always_comb begin
        respDrop_s = memRespValid_i && ((state_r == FLUSH) || redirectTake_s);
    end

    // Saturating performance counters.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stallCycles_o <= 32'd0;
            flushDrops_o  <= 32'd0;
        end else begin
            if (stall_i && enable_o && (stallCycles_o != 32'hFFFF_FFFF)) begin
                stallCycles_o <= stallCycles_o + 32'd1;
            end
            if (respDrop_s && (flushDrops_o != 32'hFFFF_FFFF)) begin
                flushDrops_o <= flushDrops_o + 32'd1;
            end
        end
    end
`endif

    fetch_unit_checker u_checker (
        .clock     (clock_i),
        .reset     (reset_i),
        .respWrite (respWrite_s),
        .fifoFull  (fifoFull_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based reference model tracks
// requests in flight, buffered instructions and redirect epochs, and every
// DUT output is compared against it on the falling clock edge.
module tb_fetch_unit;
    localparam int AW    = 64;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start, is64, redirect, memReqReady, memRespValid, stall;
    logic [63:0] startAddr, redirectAddr;
    logic [19:0] pid;
    logic [15:0] tid;
    logic [31:0] memRespData;

    logic        memReq_o, enable_o, is64Bit_o;
    logic [63:0] memAddr_o, instructionAddress_o, instructionMajId_o;
    logic [31:0] instruction_o;
    logic [19:0] instructionPid_o;
    logic [15:0] instructionTid_o;

    always #5 clock = ~clock;

    fetch_unit #(.addressWidth(AW), .instructionWidth(32), .PidSize(20), .TidSize(16),
                 .instructionCounterWidth(64), .fifoDepth(DEPTH)) dut (
        .clock_i(clock), .reset_i(reset), .start_i(start), .startAddress_i(startAddr),
        .is64Bit_i(is64), .pid_i(pid), .tid_i(tid), .redirect_i(redirect),
        .redirectAddress_i(redirectAddr), .memReq_o(memReq_o), .memAddr_o(memAddr_o),
        .memReqReady_i(memReqReady), .memRespValid_i(memRespValid),
        .memRespData_i(memRespData), .stall_i(stall), .enable_o(enable_o),
        .instruction_o(instruction_o), .instructionAddress_o(instructionAddress_o),
        .is64Bit_o(is64Bit_o), .instructionPid_o(instructionPid_o),
        .instructionTid_o(instructionTid_o), .instructionMajId_o(instructionMajId_o));

    typedef struct {
        logic [63:0] addr;
        logic        mode;
        logic [19:0] pid;
        logic [15:0] tid;
        int          epoch;
    } req_t;

    req_t        pendQ[$];   // accepted requests awaiting a response
    req_t        outQ[$];    // responses buffered for decode
    int          epoch;
    bit          started;
    logic [63:0] expPc, expMajId;
    logic        mEn, mMode;
    logic [31:0] mInstr;
    logic [63:0] mAddr, mMajId;
    logic [19:0] mPid;
    logic [15:0] mTid;
    logic        sawReq;
    logic [63:0] sawAddr;
    int          assertCount = 0;
    int          failCount = 0;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dataFor(input logic [63:0] a);
        return a[31:0] ^ {a[7:0], a[31:8]} ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] nextPc(input logic [63:0] pc, input logic mode);
        logic [63:0] n;
        n = pc + 64'd4;
        return mode ? n : {32'd0, n[31:0]};
    endfunction

    function automatic int staleCount();
        int n = 0;
        foreach (pendQ[i]) if (pendQ[i].epoch != epoch) n++;
        return n;
    endfunction

    function automatic bit expectReq();
        return started && (staleCount() == 0) && ((outQ.size() + pendQ.size()) < DEPTH);
    endfunction

    task automatic resetModel();
        pendQ.delete(); outQ.delete();
        epoch = 0; started = 0; expPc = 64'd0; expMajId = 64'd0;
        mEn = 0; mMode = 0; mInstr = 32'd0; mAddr = 64'd0; mMajId = 64'd0; mPid = 20'd0; mTid = 16'd0;
    endtask

    task automatic updateModel();
        req_t r;
        bit   redirEff;
        redirEff = redirect && started;
        if (sawReq && memReqReady) begin
            checkEq("reqAddr", sawAddr, expPc);
            r.addr = expPc; r.mode = is64; r.pid = pid; r.tid = tid; r.epoch = epoch;
            pendQ.push_back(r);
            expPc = nextPc(expPc, is64);
        end
        if (redirEff) begin
            mEn = 0;
            outQ.delete();
            epoch++;
            expPc = redirectAddr & ~64'd3;
        end else if (!stall) begin
            if (outQ.size() > 0) begin
                r = outQ.pop_front();
                mEn = 1; mInstr = dataFor(r.addr); mAddr = r.addr; mMode = r.mode;
                mPid = r.pid; mTid = r.tid; mMajId = expMajId;
                expMajId = expMajId + 64'd1;
            end else begin
                mEn = 0;
            end
        end
        if (memRespValid && pendQ.size() > 0) begin
            r = pendQ.pop_front();
            if (r.epoch == epoch) outQ.push_back(r);
        end
        if (start && !started) begin
            started = 1;
            expPc = startAddr & ~64'd3;
        end
    endtask

    task automatic checkOutputs();
        checkEq("memReq", memReq_o, expectReq());
        checkEq("memAddr", memAddr_o, expPc);
        checkEq("enable", enable_o, mEn);
        checkEq("instr", instruction_o, mInstr);
        checkEq("instrAddr", instructionAddress_o, mAddr);
        checkEq("mode", is64Bit_o, mMode);
        checkEq("pid", instructionPid_o, mPid);
        checkEq("tid", instructionTid_o, mTid);
        checkEq("majId", instructionMajId_o, mMajId);
    endtask

    // One clock: observe the request, advance the model, check on the falling edge.
    task automatic step();
        sawReq = memReq_o;
        sawAddr = memAddr_o;
        @(posedge clock);
        updateModel();
        @(negedge clock);
        checkOutputs();
        start = 0; redirect = 0; memRespValid = 0;
        pid = 20'($urandom); tid = 16'($urandom);
    endtask

    task automatic driveResp(input int pct);
        if (pendQ.size() > 0 && $urandom_range(99) < pct) begin
            memRespValid = 1;
            memRespData = dataFor(pendQ[0].addr);
        end
    endtask

    task automatic syncReset();
        reset = 1;
        start = 0; redirect = 0; memRespValid = 0; stall = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 0;
        resetModel();
    endtask

    initial begin
        logic [63:0] savedMaj;
        bit hit;
        start = 0; startAddr = 64'd0; is64 = 1; pid = 20'd0; tid = 16'd0;
        redirect = 0; redirectAddr = 64'd0; memReqReady = 0; memRespValid = 0;
        memRespData = 32'd0; stall = 0;
        resetModel();
        syncReset();
        checkOutputs();

        // Streaming from 0x1000 with an always-ready memory.
        memReqReady = 1; start = 1; startAddr = 64'h1000;
        step();
        checkEq("startAddr", memAddr_o, 64'h1000);
        repeat (12) begin driveResp(100); step(); end

        // Decode stall: buffer fills, requests stop, then drains in order.
        stall = 1;
        repeat (5) begin driveResp(100); step(); end
        checkEq("stallNoReq", memReq_o, 1'b0);
        stall = 0;
        repeat (10) begin driveResp(100); step(); end

        // 32-bit mode PC wrap.
        syncReset();
        is64 = 0; memReqReady = 1; start = 1; startAddr = 64'hFFFF_FFF8;
        step();
        step();
        step();
        checkEq("wrapAddr", memAddr_o, 64'h0);
        repeat (10) begin driveResp(100); step(); end

        // Three requests in flight, then redirect to 0x2000.
        is64 = 1;
        for (int i = 0; i < 30 && !(pendQ.size() == 3 && outQ.size() == 0); i++) begin
            memReqReady = (pendQ.size() < 3);
            if (pendQ.size() > 3) driveResp(100);
            step();
        end
        checkEq("setup3Outstanding", (pendQ.size() == 3 && outQ.size() == 0), 1'b1);
        savedMaj = expMajId;
        memReqReady = 0; redirect = 1; redirectAddr = 64'h2000;
        step();
        checkEq("flushNoReq", memReq_o, 1'b0);
        memReqReady = 1;
        repeat (3) begin driveResp(100); step(); end
        for (int i = 0; i < 20 && !enable_o; i++) begin driveResp(100); step(); end
        checkEq("redirectEnable", enable_o, 1'b1);
        checkEq("redirectFirstAddr", instructionAddress_o, 64'h2000);
        checkEq("majIdNoGap", instructionMajId_o, savedMaj);

        // Asynchronous reset while a stalled valid output is held.
        repeat (6) begin driveResp(100); step(); end
        stall = 1;
        driveResp(100); step();
        #2 reset = 1;
        #1;
        checkEq("asyncEnable", enable_o, 1'b0);
        checkEq("asyncMemReq", memReq_o, 1'b0);
        checkEq("asyncMajId", instructionMajId_o, 64'd0);
        checkEq("asyncAddr", instructionAddress_o, 64'd0);
        checkEq("asyncPc", memAddr_o, 64'd0);
        @(negedge clock);
        reset = 0; stall = 0; memRespValid = 0;
        resetModel();
        repeat (3) step();

        // Redirect coinciding with a response and an accepted request.
        start = 1; startAddr = 64'h8000; memReqReady = 1;
        step();
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (expectReq() && pendQ.size() > 0) begin
                redirect = 1; redirectAddr = 64'h9000;
                memRespValid = 1; memRespData = dataFor(pendQ[0].addr);
                hit = 1;
            end else begin
                driveResp(50);
            end
            step();
        end
        checkEq("coincidentReached", hit, 1'b1);
        checkEq("coincidentFlush", memReq_o, 1'b0);
        repeat (15) begin driveResp(100); step(); end

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            stall = ($urandom_range(3) == 0);
            memReqReady = ($urandom_range(3) != 0);
            if ($urandom_range(199) == 0) is64 = ~is64;
            if ($urandom_range(39) == 0) begin
                redirect = 1;
                redirectAddr = is64 ? {$urandom, $urandom} : {32'd0, $urandom};
            end
            driveResp(60);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage: producer side of the decode stage's input interface.
- Issues in-order word requests to instruction memory and buffers returned 32-bit instructions in a small FIFO.
- Presents buffered instructions to decode with address, mode, PID/TID and a monotonically increasing major ID, honouring decode's stall.
- Handles redirects (branch/exception) by flushing the buffer and discarding in-flight responses.

Parameters:
- addressWidth, 64, instruction address width
- instructionWidth, 32, fixed POWER instruction size
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major ID width
- fifoDepth, 4, instruction buffer entries (power of 2, ≥2)

Ports:
- clock_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- start_i  in  1  one-cycle pulse: begin fetching at startAddress_i (IDLE only)
- startAddress_i  in  addressWidth  initial PC
- is64Bit_i  in  1  mode: 1 = 64-bit addressing, 0 = 32-bit (PC wraps at 2^32)
- pid_i  in  PidSize  current process ID
- tid_i  in  TidSize  current thread ID
- redirect_i  in  1  flush and restart at redirectAddress_i
- redirectAddress_i  in  addressWidth  redirect target
- memReq_o  out  1  fetch request valid
- memAddr_o  out  addressWidth  fetch address (word aligned)
- memReqReady_i  in  1  memory accepts request this cycle
- memRespValid_i  in  1  response valid (in request order, ≥1 cycle after acceptance)
- memRespData_i  in  instructionWidth  fetched instruction
- stall_i  in  1  decode stall
- enable_o  out  1  instruction valid to decode
- instruction_o  out  instructionWidth  instruction
- instructionAddress_o  out  addressWidth  instruction address
- is64Bit_o  out  1  mode captured at request time
- instructionPid_o  out  PidSize  PID captured at request time
- instructionTid_o  out  TidSize  TID captured at request time
- instructionMajId_o  out  instructionCounterWidth  major ID

Behaviour:
- Reset (async): state IDLE; PC, majId, FIFO pointers, outstanding and drop counters = 0; all outputs 0.
- States:
  - IDLE: no requests. start_i → PC = startAddress_i, go RUN.
  - RUN: memReq_o = 1 when credits > 0, where credits = fifoDepth − occupancy − outstanding. Request accepted when memReq_o && memReqReady_i: PC += 4, outstanding++.
  - FLUSH: memReq_o = 0; each memRespValid_i decrements dropCount, data discarded. dropCount == 0 → RUN.
- Per accepted request, a side queue records {address, is64Bit_i, pid_i, tid_i}, tagged to the response; response plus tag is written to the FIFO; outstanding--.
- PC arithmetic: PC + 4 modulo 2^64. When is64Bit_i = 0, bits above 31 are forced to 0 (0xFFFF_FFFC → 0x0). Low 2 bits of PC are always 0; start and redirect addresses have bits [1:0] cleared.
- Output register:
  - When !stall_i and FIFO non-empty: pop; enable_o = 1 next cycle; instructionMajId_o = majId; majId++.
  - When !stall_i and FIFO empty: enable_o = 0; other outputs hold.
  - When stall_i = 1: all outputs hold, no pop.
- Latency: response at edge N → enable_o at edge N+1 (no bypass).
- majId wraps modulo 2^instructionCounterWidth. It is not reset by redirect; only reset_i clears it.
- redirect_i (any state except IDLE):
  - FIFO emptied; enable_o = 0 next cycle; PC = redirectAddress_i.
  - dropCount = outstanding (a response arriving the same cycle counts as already dropped).
  - Go FLUSH if dropCount > 0, else RUN.
  - A request accepted in the redirect cycle is counted in dropCount.
- redirect_i in IDLE is ignored. start_i outside IDLE is ignored. redirect_i wins over start_i.
- FIFO can never overflow because of the credit rule. A response arriving with the FIFO full is an assertion failure.

Optional Feature:
- FETCH_PERF_CTR_EN: adds outputs stallCycles_o (32-bit, counts cycles with stall_i && enable_o) and flushDrops_o (32-bit, counts discarded responses). Both saturate at all-ones and reset to 0.
- Without the macro, neither the ports nor the logic exist.

Test Plan:
- Reset, start_i with startAddress_i = 0x1000, memReqReady_i = 1, responses 1 cycle later → enable_o stream at addresses 0x1000, 0x1004, 0x1008…; majId 0, 1, 2…; back-to-back one per cycle.
- Hold stall_i for 5 cycles with fifoDepth = 4 → outputs frozen, exactly 4 buffered, memReq_o = 0 once credits = 0; release → drains in order with no loss or duplication.
- is64Bit_i = 0, start at 0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- 3 requests outstanding, redirect_i to 0x2000 → 3 late responses discarded, FSM passes through FLUSH, next enable_o address = 0x2000, majId continues without a gap.
- Assert reset_i mid-stream with stalled valid output → enable_o and all counters 0 immediately (asynchronous), FSM IDLE, no memReq_o until start_i.
- redirect_i coincident with a response and an accepted request → both are discarded; dropCount covers the new request.
